// File: rtl/delay_pkg.sv
// Shared helpers for the programmable delay line: select-port width and
// tap clamping.
package delay_pkg;

    // Width needed to express every delay value from 0 to max_delay.
    function automatic int unsigned delay_width(input int unsigned max_delay);
        int unsigned w;
        if (max_delay < 32'd1) begin
            w = 32'd1;
        end else begin
            w = $clog2(max_delay + 32'd1);
        end
        return w;
    endfunction

    // Force a requested delay into the legal tap range 1..max_delay.
    function automatic int unsigned clamp_delay(input int unsigned value,
                                                input int unsigned max_delay);
        int unsigned d;
        if (value < 32'd1) begin
            d = 32'd1;
        end else if (value > max_delay) begin
            d = max_delay;
        end else begin
            d = value;
        end
        return d;
    endfunction

endpackage

// File: rtl/delay_stage.sv
// One register stage of the delay line.
// Priority is reset, then flush, then enable, then hold.
module delay_stage #(
    parameter int unsigned W = 9
) (
    input  logic         iclock,
    input  logic         ireset,
    input  logic         iflush,
    input  logic         ienable,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Stage register; a clear always wins over a shift.
    always_ff @(posedge iclock) begin
        if (ireset) begin
            q_r <= '0;
        end else if (iflush) begin
            q_r <= '0;
        end else if (ienable) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/delay_line_prog.sv
// Run-time programmable delay line: {ivalid, idata} delayed by 1..MAX_DELAY
// enabled clock edges, with stall, flush and a per-stage valid flag.
module delay_line_prog
    import delay_pkg::*;
#(
    parameter  int unsigned WIDTH     = 8,
    parameter  int unsigned MAX_DELAY = 4,
    localparam int unsigned DW        = delay_width(MAX_DELAY)
) (
    input  logic             iclock,
    input  logic             ireset,
    input  logic             ienable,
    input  logic             iflush,
    input  logic [DW-1:0]    idelay,
    input  logic             ivalid,
    input  logic [WIDTH-1:0] idata,
    output logic             ovalid,
    output logic [WIDTH-1:0] odata
);

    localparam int unsigned SW = WIDTH + 32'd1;

    logic [SW-1:0] stage_in_s [1:MAX_DELAY];
    logic [SW-1:0] stage_q_s  [1:MAX_DELAY];
    logic [DW-1:0] tap_idx_s;
    logic [SW-1:0] tap_s;

    for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_stage
        if (k == 1) begin : g_head
            assign stage_in_s[k] = {ivalid, idata};
        end else begin : g_body
            assign stage_in_s[k] = stage_q_s[k-1];
        end

        delay_stage #(
            .W (SW)
        ) u_stage (
            .iclock  (iclock),
            .ireset  (ireset),
            .iflush  (iflush),
            .ienable (ienable),
            .d       (stage_in_s[k]),
            .q       (stage_q_s[k])
        );
    end

    // Tap select: registers only, so idata/ivalid never reach the outputs
    // combinationally; a change of idelay takes effect in the same cycle.
    always_comb begin
        tap_idx_s = DW'(clamp_delay(32'(idelay), MAX_DELAY));
        tap_s     = stage_q_s[tap_idx_s];
    end

    assign ovalid = tap_s[SW-1];
    assign odata  = tap_s[WIDTH-1:0];

endmodule

// File: tb/tb_delay_line_prog.sv
// Self-checking bench for delay_line_prog (WIDTH=8, MAX_DELAY=4): history model
// compared every cycle, plus directed literal expectations.
module tb_delay_line_prog;

    localparam int WIDTH = 8;
    localparam int MAXD  = 4;
    localparam int DW    = 3;

    logic             clk = 1'b0;
    logic             ireset = 1'b1;
    logic             ienable = 1'b0;
    logic             iflush = 1'b0;
    logic [DW-1:0]    idelay = 3'd2;
    logic             ivalid = 1'b0;
    logic [WIDTH-1:0] idata = 8'h00;
    logic             ovalid;
    logic [WIDTH-1:0] odata;

    int checks = 0;
    int failures = 0;

    // History of accepted words, newest first; clears refill it with zeros.
    logic [WIDTH:0] hist [$];

    delay_line_prog #(.WIDTH(WIDTH), .MAX_DELAY(MAXD)) dut (
        .iclock  (clk),
        .ireset  (ireset),
        .ienable (ienable),
        .iflush  (iflush),
        .idelay  (idelay),
        .ivalid  (ivalid),
        .idata   (idata),
        .ovalid  (ovalid),
        .odata   (odata)
    );

    always #5 clk = ~clk;

    function automatic int eff_delay(input logic [DW-1:0] v);
        if (v == 3'd0) return 1;
        if (int'(v) > MAXD) return MAXD;
        return int'(v);
    endfunction

    task automatic check(input string name, input logic gv, input logic [WIDTH-1:0] gd,
                         input logic wv, input logic [WIDTH-1:0] wd);
        checks++;
        if (gv !== wv || gd !== wd) begin
            failures++;
            $display("FAIL %s: got valid=%0b data=%02h, want valid=%0b data=%02h",
                     name, gv, gd, wv, wd);
        end
    endtask

    initial begin
        for (int i = 0; i < MAXD; i++) hist.push_back('0);
    end

    // Model update on each edge, then per-cycle comparison 1 time unit later.
    always @(posedge clk) begin
        if (ireset || iflush) begin
            hist.delete();
            for (int i = 0; i < MAXD; i++) hist.push_back('0);
        end else if (ienable) begin
            hist.push_front({ivalid, idata});
            void'(hist.pop_back());
        end
        #1;
        begin
            logic [WIDTH:0] e;
            e = hist[eff_delay(idelay) - 1];
            check("model", ovalid, odata, e[WIDTH], e[WIDTH-1:0]);
        end
    end

    // One clock cycle: drive on the falling edge, return 2 units after rising edge.
    task automatic cyc(input logic rs, input logic fl, input logic en,
                       input logic [DW-1:0] dly, input logic v, input logic [WIDTH-1:0] d);
        @(negedge clk);
        ireset = rs; iflush = fl; ienable = en; idelay = dly; ivalid = v; idata = d;
        @(posedge clk);
        #2;
    endtask

    initial begin
        // Reset
        cyc(1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 8'hFF);
        check("reset_state", ovalid, odata, 1'b0, 8'h00);

        // 1: delay 2 stream
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h11);
        check("d2_first_edge", ovalid, odata, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h22);
        check("d2_w0", ovalid, odata, 1'b1, 8'h11);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h33);
        check("d2_w1", ovalid, odata, 1'b1, 8'h22);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00);
        check("d2_w2", ovalid, odata, 1'b1, 8'h33);

        // 2: idelay 0 clamps to 1
        cyc(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 8'hA5);
        check("d0_pulse", ovalid, odata, 1'b1, 8'hA5);
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00);
        check("d0_after", ovalid, odata, 1'b0, 8'h00);
        //    idelay 7 clamps to 4
        cyc(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 8'hA5);
        cyc(1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00);
        check("d7_early", ovalid, odata, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 8'h00);
        check("d7_pulse", ovalid, odata, 1'b1, 8'hA5);

        // 3: stall at delay 3
        cyc(1'b0, 1'b1, 1'b1, 3'd3, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 8'h5A);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'hEE);
            check("stall_hold", ovalid, odata, 1'b0, 8'h00);
        end
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00);
        check("stall_not_yet", ovalid, odata, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00);
        check("stall_emerge", ovalid, odata, 1'b1, 8'h5A);
        cyc(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h77);
        cyc(1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h77);
        check("stall_out_hold", ovalid, odata, 1'b1, 8'h5A);

        // 4: flush with words in flight; word offered with flush is dropped
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'hC1);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'hC2);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'hC3);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'hC4);
        check("flush_pre", ovalid, odata, 1'b1, 8'hC1);
        cyc(1'b0, 1'b1, 1'b1, 3'd4, 1'b1, 8'hEE);
        check("flush_clear", ovalid, odata, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'h77);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00);
        check("flush_gap", ovalid, odata, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00);
        check("flush_reentry", ovalid, odata, 1'b1, 8'h77);

        // Tap switch mid-stream: shorter delay skips, longer re-presents
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'h41);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'h42);
        cyc(1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 8'h43);
        check("tap_shorten", ovalid, odata, 1'b1, 8'h43);
        cyc(1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00);
        check("tap_lengthen", ovalid, odata, 1'b1, 8'h41);

        // 5: reset mid-stream with enable and valid high
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h10);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 1'b1, 8'h20);
        cyc(1'b1, 1'b0, 1'b1, 3'd2, 1'b1, 8'h99);
        check("reset_mid", ovalid, odata, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00);
        check("reset_drop", ovalid, odata, 1'b0, 8'h00);

        // 6: valid pattern 1,0,1 at delay 4
        cyc(1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'h01);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'hFF);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b1, 8'h03);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00);
        check("vpat_0", ovalid, odata, 1'b1, 8'h01);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00);
        check("vpat_1", ovalid, odata, 1'b0, 8'hFF);
        cyc(1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 8'h00);
        check("vpat_2", ovalid, odata, 1'b1, 8'h03);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
